// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: the NOP word
// returned on access faults and the encoding of the fetch FSM states.
package imem_responder_pkg;

   // RISC-V "addi x0, x0, 0", returned in place of data on any access fault.
   localparam logic [31:0] NOP_WORD = 32'h00000013;

   // Fetch FSM: accepting, counting down latency, presenting the response.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } fetch_state_e;

endpackage : imem_responder_pkg

// File: rtl/imem_array.sv
// Instruction word storage: one write port for program load and one read
// port that captures the addressed word into a holding register on rd_en.
// A write and a capture of the same word in one cycle capture the old word.
module imem_array #(
   parameter int width = 32,
   parameter int DEPTH = 256,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [width-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [width-1:0] rd_data
);

   logic [width-1:0] mem [DEPTH];

   // Program-load write and read capture share one clocked process so the
   // capture sees the pre-write contents of the array.
   // NOTE: the array and its capture register carry no reset; contents must
   // survive a reset of the fetch logic, and the responder gates rd_data
   // whenever no response is being presented.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule : imem_array

// File: rtl/imem_responder.sv
// Single-outstanding instruction fetch responder with fixed response latency.
// Requests are accepted only in IDLE; the word and its fault flag are
// captured at acceptance and presented LATENCY cycles later until consumed.
// Optional build macro: IMEM_MISALIGN_CHECK_EN -- when defined, a request
// whose byte address is not word aligned returns an access fault.
module imem_responder
   import imem_responder_pkg::*;
#(
   parameter int width   = 32,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [width-1:0] req_addr,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [width-1:0] rsp_data,
   output logic             rsp_err,
   input  logic             ld_en,
   input  logic [AW-1:0]    ld_addr,
   input  logic [width-1:0] ld_data
);

`ifdef IMEM_MISALIGN_CHECK_EN
   localparam bit MISALIGN_EN = 1'b1;
`else
   localparam bit MISALIGN_EN = 1'b0;
`endif

   // First byte address past the end of the array.
   localparam logic [width-1:0] ADDR_LIMIT = width'(4 * DEPTH);
   localparam logic [1:0]       CNT_LOAD   = 2'(LATENCY - 1);

   fetch_state_e     state, state_nxt;
   logic [1:0]       cnt, cnt_nxt;
   logic             err_q;
   logic             accept;
   logic             range_fault;
   logic             align_fault;
   logic [width-1:0] word_q;

   assign accept      = req_valid & req_ready;
   assign range_fault = (req_addr >= ADDR_LIMIT);
   assign align_fault = MISALIGN_EN && (req_addr[1:0] != 2'b00);

   imem_array #(
      .width (width),
      .DEPTH (DEPTH)
   ) u_array (
      .clk     (clk),
      .wr_en   (ld_en),
      .wr_addr (ld_addr),
      .wr_data (ld_data),
      .rd_en   (accept),
      .rd_addr (req_addr[AW+1:2]),
      .rd_data (word_q)
   );

   // State, latency counter and captured fault flag; reset aborts any fetch.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before this edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= 2'd0;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            err_q <= range_fault | align_fault;
         end
      end
   end

   // Next-state logic: the counter reaching zero in WAIT releases the response.
   // NOTE: defaults come first so no path leaves a variable unassigned, which
   // would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_nxt = RESP;
                  cnt_nxt   = 2'd0;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (cnt <= 2'd1) begin
               state_nxt = RESP;
               cnt_nxt   = 2'd0;
            end else begin
               cnt_nxt = cnt - 2'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 2'd0;
         end
      endcase
   end

   // Handshake and response outputs depend on state only; data is zeroed
   // whenever no response is valid.
   always_comb begin
      req_ready = (state == IDLE);
      rsp_valid = (state == RESP);
      rsp_err   = 1'b0;
      rsp_data  = '0;
      if (state == RESP) begin
         rsp_err  = err_q;
         rsp_data = err_q ? width'(NOP_WORD) : word_q;
      end
   end

endmodule : imem_responder

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios followed by
// randomized fetches against an array-based reference model.
// Honours IMEM_MISALIGN_CHECK_EN when the build defines it.
`timescale 1ns/1ps
module tb_imem_responder;

   localparam int WIDTH = 32;
   localparam int DEPTH = 256;
   localparam int LAT   = 2;
   localparam logic [31:0] NOP = 32'h00000013;
`ifdef IMEM_MISALIGN_CHECK_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        ld_en = 1'b0;
   logic [7:0]  ld_addr = '0;
   logic [31:0] ld_data = '0;

   logic [31:0] mem [DEPTH];
   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   imem_responder #(.width(WIDTH), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected response from the fault rules and the current memory image.
   task automatic model_rsp(input logic [31:0] addr, output logic [31:0] d, output logic e);
      e = (addr >= 32'(4 * DEPTH)) || (MIS && (addr % 4 != 0));
      d = e ? NOP : mem[(addr / 4) % DEPTH];
   endtask

   task automatic load_word(input int idx, input logic [31:0] val);
      ld_en = 1'b1; ld_addr = 8'(idx); ld_data = val;
      @(posedge clk); @(negedge clk);
      ld_en = 1'b0;
      mem[idx] = val;
   endtask

   // One complete fetch. cld: program load at the acceptance edge;
   // pld: load to the fetched word while the response is being held.
   task automatic fetch(input logic [31:0] addr, input int hold,
                        input bit cld, input int cidx, input logic [31:0] cval,
                        input bit pld, input logic [31:0] pval);
      logic [31:0] ed;
      logic        ee;
      int          n;
      model_rsp(addr, ed, ee);
      check("req_ready_before", req_ready, 1);
      req_valid = 1'b1; req_addr = addr;
      if (cld) begin ld_en = 1'b1; ld_addr = 8'(cidx); ld_data = cval; end
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0; req_addr = $urandom; ld_en = 1'b0;
      if (cld) mem[cidx] = cval;
      n = 1;
      while (!rsp_valid && n <= 8) begin
         check("idle_rsp_data", rsp_data, 0);
         check("idle_rsp_err", rsp_err, 0);
         check("busy_req_ready", req_ready, 0);
         @(posedge clk); @(negedge clk);
         n++;
      end
      check("latency", n, LAT);
      if (!rsp_valid) return;
      check("rsp_data", rsp_data, ed);
      check("rsp_err", rsp_err, ee);
      for (int i = 0; i < hold; i++) begin
         rsp_ready = 1'b0;
         if (i == 0 && pld) begin
            ld_en = 1'b1; ld_addr = addr[9:2]; ld_data = pval;
            mem[addr[9:2]] = pval;
         end
         @(posedge clk); @(negedge clk);
         ld_en = 1'b0;
         check("hold_rsp_valid", rsp_valid, 1);
         check("hold_rsp_data", rsp_data, ed);
         check("hold_rsp_err", rsp_err, ee);
         check("hold_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      rsp_ready = 1'b0;
      check("post_rsp_valid", rsp_valid, 0);
      check("post_rsp_data", rsp_data, 0);
      check("post_rsp_err", rsp_err, 0);
      check("post_req_ready", req_ready, 1);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] ed;
      logic        ee;
      int          r;

      // Reset and fill the whole array with random words.
      @(negedge clk);
      for (int i = 0; i < DEPTH; i++) begin
         ld_en = 1'b1; ld_addr = 8'(i); ld_data = $urandom;
         mem[i] = ld_data;
         @(posedge clk); @(negedge clk);
      end
      ld_en = 1'b0;
      check("rst_req_ready", req_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_err", rsp_err, 0);

      // Basic fetch of a known instruction after reset.
      load_word(1, 32'h00500093);
      reset_n = 1'b0;
      @(posedge clk); @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); @(negedge clk);
      fetch(32'h4, 0, 0, 0, 0, 0, 0);
      // Back-pressure for three cycles.
      fetch(32'h4, 3, 0, 0, 0, 0, 0);
      // Out of range and misaligned addresses.
      fetch(32'h400, 1, 0, 0, 0, 0, 0);
      fetch(32'h6, 0, 0, 0, 0, 0, 0);

      // Reset while the request is still counting down.
      load_word(2, 32'h12345678);
      req_valid = 1'b1; req_addr = 32'h8;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      reset_n = 1'b0;
      @(posedge clk); @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("abort_rsp_valid", rsp_valid, 0);
         check("abort_req_ready", req_ready, 1);
         @(posedge clk); @(negedge clk);
      end
      fetch(32'h8, 0, 0, 0, 0, 0, 0);

      // Same-cycle load and acceptance of one word returns the old word.
      load_word(3, NOP);
      fetch(32'hC, 0, 1, 3, 32'hDEADBEEF, 0, 0);
      model_rsp(32'hC, ed, ee);
      check("model_new_word", ed, 32'hDEADBEEF);
      fetch(32'hC, 0, 0, 0, 0, 0, 0);

      // Randomized fetches with concurrent and later loads.
      for (int k = 0; k < 80; k++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      a = 32'h400 + $urandom_range(0, 32'h7FFF0000);
         else if (r == 1) a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
         else             a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         fetch(a, $urandom_range(0, 3),
               bit'($urandom_range(0, 2) == 0),
               ($urandom_range(0, 1) == 0) ? int'(a[9:2]) : $urandom_range(0, DEPTH - 1),
               $urandom,
               bit'($urandom_range(0, 1)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute time bound so the bench always terminates.
   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "time limit");
   end

endmodule : tb_imem_responder

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter: width, 32, data and address width in bits.
REQ-002 Parameter: DEPTH, 256, number of instruction words stored; power of two.
REQ-003 Parameter: LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..4.
REQ-004 Port: clk  input  1  single clock; all logic rising-edge.
REQ-005 Port: reset_n  input  1  synchronous, active-low reset.
REQ-006 Port: req_valid  input  1  fetch request from PC/fetch stage.
REQ-007 Port: req_ready  output  1  block can accept a request.
REQ-008 Port: req_addr  input  width  byte address of instruction (the PC value).
REQ-009 Port: rsp_valid  output  1  response data/err valid.
REQ-010 Port: rsp_ready  input  1  consumer accepts response.
REQ-011 Port: rsp_data  output  width  fetched instruction word.
REQ-012 Port: rsp_err  output  1  access fault for this response.
REQ-013 Port: ld_en  input  1  program-load write strobe.
REQ-014 Port: ld_addr  input  log2(DEPTH)  word index for program load.
REQ-015 Port: ld_data  input  width  word written on ld_en.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT, RESP; single outstanding request.
REQ-017 req_ready SHALL be 1 only in IDLE; acceptance = req_valid & req_ready at a rising edge.
REQ-018 On acceptance, the block SHALL capture the word at index req_addr[log2(DEPTH)+1:2] plus fault flags, load counter with LATENCY-1, and go to WAIT (LATENCY=1: directly RESP).
REQ-019 WAIT SHALL decrement counter each cycle; at 0 go to RESP, so rsp_valid rises exactly LATENCY cycles after acceptance edge.
REQ-020 In RESP, rsp_valid=1; rsp_data/rsp_err SHALL hold stable until rsp_valid & rsp_ready, then go to IDLE.
REQ-021 Back-to-back: new request SHALL be accepted no earlier than the cycle after response handshake (req_ready combinational from state only).
REQ-022 Out-of-range (req_addr >= 4*DEPTH): rsp_err=1, rsp_data=32'h00000013 (NOP).
REQ-023 Load write and acceptance in the same cycle to same word: response SHALL return the old word (read-before-write); later loads SHALL not alter a captured response.
REQ-024 ld_en SHALL write memory in any state; memory has no reset.
REQ-025 rsp_data SHALL be 0 and rsp_err 0 whenever rsp_valid=0.

Reset
REQ-026 reset_n=0 at a clock edge SHALL force IDLE, counter 0, rsp_valid=0, rsp_data=0, rsp_err=0, req_ready=1 after release.
REQ-027 Reset mid-WAIT or mid-RESP SHALL abort the request with no response; memory contents preserved.

Configuration
REQ-028 Macro IMEM_MISALIGN_CHECK_EN defined: req_addr[1:0]!=0 SHALL give rsp_err=1, rsp_data=NOP, same latency.
REQ-029 Macro undefined: req_addr[1:0] ignored, no misalignment fault; range fault per REQ-022 unchanged.

Structure
REQ-030 Shared package SHALL hold NOP constant 32'h00000013 and FSM state encoding (IDLE/WAIT/RESP).
REQ-031 Storage SHALL be sub-module imem_array (one write port, one synchronous-capture read); FSM/handshake in imem_responder.

Verification
REQ-032 Load word 1 = 32'h00500093; reset; req_addr=4, LATENCY=2 -> rsp_valid 2 cycles after acceptance, rsp_data=32'h00500093, rsp_err=0.
REQ-033 rsp_ready held 0 for 3 cycles in RESP -> rsp_valid/rsp_data stable, req_ready=0; rsp_ready=1 -> IDLE, req_ready=1 next cycle.
REQ-034 req_addr=32'h00000400 (DEPTH=256) -> rsp_err=1, rsp_data=32'h00000013.
REQ-035 req_addr=32'h00000006: with IMEM_MISALIGN_CHECK_EN -> rsp_err=1, NOP; without -> word 1 data, rsp_err=0.
REQ-036 Accept req_addr=8, assert reset_n=0 in WAIT -> no rsp_valid; after release req_ready=1, word 2 still readable unchanged.
REQ-037 ld_en to word 3 with 32'hDEADBEEF in same cycle as acceptance of req_addr=12 (old 32'h00000013) -> response 32'h00000013; next fetch -> 32'hDEADBEEF.
